// File: rtl/cci_mpf_prim_ram_byteena_init_fwd_pkg.sv
// Shared types and helpers for the self-initialising byte-enable RAM.
// Width-generic operations are carried at MERGE_MAX_BITS and cast at the call site.
package cci_mpf_prim_ram_pkg;

  localparam int unsigned MERGE_MAX_BITS = 512;
  localparam int unsigned MERGE_IDX_W    = $clog2(MERGE_MAX_BITS);

  typedef enum logic [0:0] {
    RAM_STATE_INIT  = 1'b0,
    RAM_STATE_READY = 1'b1
  } t_ram_init_state;

  // Lanes whose byteena bit is set take new_data; all other bits keep old_data.
  function automatic logic [MERGE_MAX_BITS-1:0] byte_merge(
    input logic [MERGE_MAX_BITS-1:0] old_data,
    input logic [MERGE_MAX_BITS-1:0] new_data,
    input logic [MERGE_MAX_BITS-1:0] byteena,
    input int unsigned               n_byte_bits
  );
    logic [MERGE_MAX_BITS-1:0] merged;
    int unsigned lane;
    merged = old_data;
    for (int unsigned b = 0; b < MERGE_MAX_BITS; b++) begin
      lane = b / n_byte_bits;
      if (byteena[MERGE_IDX_W'(lane)]) begin
        merged[MERGE_IDX_W'(b)] = new_data[MERGE_IDX_W'(b)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_byteena_init_fwd_if.sv
// Write/read/init port bundle for the self-initialising byte-enable RAM.
interface cci_mpf_prim_ram_byteena_init_fwd_if #(
  parameter int unsigned N_ENTRIES   = 32,
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned N_BYTE_BITS = 8
);
  localparam int unsigned ADDR_W  = $clog2(N_ENTRIES);
  localparam int unsigned N_BYTES = N_DATA_BITS / N_BYTE_BITS;

  logic                   init_req;
  logic                   rdy;
  logic                   wen;
  logic [ADDR_W-1:0]      waddr;
  logic [N_BYTES-1:0]     wbyteena;
  logic [N_DATA_BITS-1:0] wdata;
  logic                   ren;
  logic [ADDR_W-1:0]      raddr;
  logic                   rvalid;
  logic [N_DATA_BITS-1:0] rdata;

  modport master (
    output init_req, wen, waddr, wbyteena, wdata, ren, raddr,
    input  rdy, rvalid, rdata
  );

  modport slave (
    input  init_req, wen, waddr, wbyteena, wdata, ren, raddr,
    output rdy, rvalid, rdata
  );

endinterface

// File: rtl/cci_mpf_prim_ram_byteena_init_fwd_core.sv
// Behavioural RAM: one byte-enabled write port, one registered read port.
// A read and write of the same word in one cycle returns the pre-write word.
module cci_mpf_prim_ram_byteena_core
  import cci_mpf_prim_ram_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 32,
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned N_BYTE_BITS = 8
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     wen,
  input  logic [$clog2(N_ENTRIES)-1:0]             waddr,
  input  logic [N_DATA_BITS/N_BYTE_BITS-1:0]       wbyteena,
  input  logic [N_DATA_BITS-1:0]                   wdata,
  input  logic                                     ren,
  input  logic [$clog2(N_ENTRIES)-1:0]             raddr,
  output logic [N_DATA_BITS-1:0]                   rdata
);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= N_DATA_BITS'(byte_merge(MERGE_MAX_BITS'(mem[waddr]),
                                            MERGE_MAX_BITS'(wdata),
                                            MERGE_MAX_BITS'(wbyteena),
                                            N_BYTE_BITS));
    end
  end

  // Read register holds its value between reads so idle cycles never show X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cci_mpf_prim_ram_byteena_init_fwd.sv
// Byte-enable simple dual-port RAM that clears itself to INIT_VALUE after reset
// or on init_req, with optional write-to-read forwarding and output pipeline.
module cci_mpf_prim_ram_byteena_init_fwd
  import cci_mpf_prim_ram_pkg::*;
#(
  parameter int unsigned            N_ENTRIES           = 32,
  parameter int unsigned            N_DATA_BITS         = 64,
  parameter int unsigned            N_BYTE_BITS         = 8,
  parameter int unsigned            N_OUTPUT_REG_STAGES = 0,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE          = N_DATA_BITS'(0),
  parameter int unsigned            BYPASS_EN           = 1
) (
  input logic clk,
  input logic reset_n,
  cci_mpf_prim_ram_byteena_init_fwd_if.slave bus
);

  localparam int unsigned ADDR_W  = $clog2(N_ENTRIES);
  localparam int unsigned N_BYTES = N_DATA_BITS / N_BYTE_BITS;
  localparam logic [ADDR_W:0]   N_ENTRIES_W = (ADDR_W+1)'(N_ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_ENTRIES - 1);

  t_ram_init_state     state, state_next;
  logic [ADDR_W-1:0]   init_addr, init_addr_next;
  logic                ready;

  logic                waddr_ok_c, raddr_ok_c, wr_accept_c, rd_accept_c;
  logic                core_wen_c;
  logic [ADDR_W-1:0]   core_waddr_c;
  logic [N_BYTES-1:0]  core_wbyteena_c;
  logic [N_DATA_BITS-1:0] core_wdata_c;
  logic [N_DATA_BITS-1:0] core_rdata;

  logic                rd0_valid, rd0_oor, byp_hit;
  logic [N_DATA_BITS-1:0] byp_data;
  logic [N_BYTES-1:0]  byp_be;
  logic [N_DATA_BITS-1:0] rd0_data_c;

  assign ready   = (state == RAM_STATE_READY);
  assign bus.rdy = ready;

  assign waddr_ok_c  = ({1'b0, bus.waddr} < N_ENTRIES_W);
  assign raddr_ok_c  = ({1'b0, bus.raddr} < N_ENTRIES_W);
  assign wr_accept_c = bus.wen && ready && waddr_ok_c;
  assign rd_accept_c = bus.ren && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RAM_STATE_INIT;
      init_addr <= '0;
    end else begin
      state     <= state_next;
      init_addr <= init_addr_next;
    end
  end

  // Init sequencing and write-port mux: the clear owns the write port in INIT.
  always_comb begin
    state_next      = state;
    init_addr_next  = init_addr;
    core_wen_c      = wr_accept_c;
    core_waddr_c    = bus.waddr;
    core_wbyteena_c = bus.wbyteena;
    core_wdata_c    = bus.wdata;
    case (state)
      RAM_STATE_INIT: begin
        core_wen_c      = 1'b1;
        core_waddr_c    = init_addr;
        core_wbyteena_c = '1;
        core_wdata_c    = INIT_VALUE;
        if (bus.init_req) begin
          init_addr_next = '0;
        end else if (init_addr == LAST_ADDR) begin
          init_addr_next = '0;
          state_next     = RAM_STATE_READY;
        end else begin
          init_addr_next = init_addr + ADDR_W'(1);
        end
      end
      RAM_STATE_READY: begin
        if (bus.init_req) begin
          state_next     = RAM_STATE_INIT;
          init_addr_next = '0;
        end
      end
      default: state_next = RAM_STATE_INIT;
    endcase
  end

  cci_mpf_prim_ram_byteena_core #(
    .N_ENTRIES   (N_ENTRIES),
    .N_DATA_BITS (N_DATA_BITS),
    .N_BYTE_BITS (N_BYTE_BITS)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .wen      (core_wen_c),
    .waddr    (core_waddr_c),
    .wbyteena (core_wbyteena_c),
    .wdata    (core_wdata_c),
    .ren      (rd_accept_c && raddr_ok_c),
    .raddr    (bus.raddr),
    .rdata    (core_rdata)
  );

  // Side-band for the read register: the coincident write is captured here so it
  // lines up with the old word coming out of the core one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd0_valid <= 1'b0;
      rd0_oor   <= 1'b0;
      byp_hit   <= 1'b0;
      byp_data  <= '0;
      byp_be    <= '0;
    end else begin
      rd0_valid <= rd_accept_c;
      if (rd_accept_c) begin
        rd0_oor  <= !raddr_ok_c;
        byp_hit  <= (BYPASS_EN != 0) && wr_accept_c && (bus.waddr == bus.raddr);
        byp_data <= bus.wdata;
        byp_be   <= bus.wbyteena;
      end
    end
  end

  always_comb begin
    rd0_data_c = core_rdata;
    if (rd0_oor) begin
      rd0_data_c = INIT_VALUE;
    end else if (byp_hit) begin
      rd0_data_c = N_DATA_BITS'(byte_merge(MERGE_MAX_BITS'(core_rdata),
                                           MERGE_MAX_BITS'(byp_data),
                                           MERGE_MAX_BITS'(byp_be),
                                           N_BYTE_BITS));
    end
  end

  // Output pipeline: data stages load only alongside a valid, so rdata holds.
  if (N_OUTPUT_REG_STAGES == 0) begin : g_direct
    assign bus.rvalid = rd0_valid;
    assign bus.rdata  = rd0_data_c;
  end else begin : g_pipe
    for (genvar k = 0; k < N_OUTPUT_REG_STAGES; k++) begin : g_stage
      logic                   valid_q;
      logic [N_DATA_BITS-1:0] data_q;
      logic                   src_valid;
      logic [N_DATA_BITS-1:0] src_data;

      if (k == 0) begin : g_src
        assign src_valid = rd0_valid;
        assign src_data  = rd0_data_c;
      end else begin : g_src
        assign src_valid = g_stage[k-1].valid_q;
        assign src_data  = g_stage[k-1].data_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= src_valid;
          if (src_valid) begin
            data_q <= src_data;
          end
        end
      end
    end
    assign bus.rvalid = g_stage[N_OUTPUT_REG_STAGES-1].valid_q;
    assign bus.rdata  = g_stage[N_OUTPUT_REG_STAGES-1].data_q;
  end

endmodule

// File: tb/tb_cci_mpf_prim_ram_byteena_init_fwd.sv
// Directed bench: 12-entry, 32-bit RAM, one output stage, with and without forwarding.
module tb_cci_mpf_prim_ram_byteena_init_fwd;

  localparam logic [31:0] IV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cci_mpf_prim_ram_byteena_init_fwd_if #(.N_ENTRIES(12), .N_DATA_BITS(32), .N_BYTE_BITS(8)) bus0 ();
  cci_mpf_prim_ram_byteena_init_fwd_if #(.N_ENTRIES(12), .N_DATA_BITS(32), .N_BYTE_BITS(8)) bus1 ();

  assign bus1.init_req = bus0.init_req;
  assign bus1.wen      = bus0.wen;
  assign bus1.waddr    = bus0.waddr;
  assign bus1.wbyteena = bus0.wbyteena;
  assign bus1.wdata    = bus0.wdata;
  assign bus1.ren      = bus0.ren;
  assign bus1.raddr    = bus0.raddr;

  cci_mpf_prim_ram_byteena_init_fwd #(
    .N_ENTRIES(12), .N_DATA_BITS(32), .N_BYTE_BITS(8), .N_OUTPUT_REG_STAGES(1),
    .INIT_VALUE(32'hDEAD_BEEF), .BYPASS_EN(1)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus0));

  cci_mpf_prim_ram_byteena_init_fwd #(
    .N_ENTRIES(12), .N_DATA_BITS(32), .N_BYTE_BITS(8), .N_OUTPUT_REG_STAGES(1),
    .INIT_VALUE(32'hDEAD_BEEF), .BYPASS_EN(0)
  ) dut_nobyp (.clk(clk), .reset_n(reset_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_count(input string tag);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("%s_rdy%0d", tag, k), 32'(bus0.rdy), 32'(k == 12));
      check($sformatf("%s_vld%0d", tag, k), 32'(bus0.rvalid), 32'd0);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    bus0.wen = 1'b1; bus0.waddr = a; bus0.wbyteena = be; bus0.wdata = d;
    tick();
    bus0.wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus0.ren = 1'b1; bus0.raddr = a;
    tick();
    bus0.ren = 1'b0;
    check({tag, "_lat"}, 32'(bus0.rvalid), 32'd0);
    tick();
    check({tag, "_vld"}, 32'(bus0.rvalid), 32'd1);
    check({tag, "_dat"}, bus0.rdata, exp);
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i <= 12; i++) begin
      bus0.ren   = (i < 12);
      bus0.raddr = (i < 12) ? 4'(i) : 4'd0;
      tick();
      if (i == 0) begin
        check({tag, "_lat"}, 32'(bus0.rvalid), 32'd0);
      end else begin
        check($sformatf("%s_vld%0d", tag, i - 1), 32'(bus0.rvalid), 32'd1);
        check($sformatf("%s_dat%0d", tag, i - 1), bus0.rdata, IV);
      end
    end
    bus0.ren = 1'b0;
    tick();
    check({tag, "_end"}, 32'(bus0.rvalid), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus0.init_req = 1'b0;
    bus0.wen      = 1'b0;
    bus0.waddr    = '0;
    bus0.wbyteena = '0;
    bus0.wdata    = '0;
    bus0.ren      = 1'b1;
    bus0.raddr    = '0;

    // Reset state
    tick();
    tick();
    check("rst_rdy", 32'(bus0.rdy), 32'd0);
    check("rst_vld", 32'(bus0.rvalid), 32'd0);
    check("rst_dat", bus0.rdata, 32'd0);
    check("rst_rdy_nb", 32'(bus1.rdy), 32'd0);

    // Init with ren held high, then sweep every entry
    reset_n = 1'b1;
    init_count("init");
    rd_all("sweep");

    // Partial byte write
    wr(4'd3, 4'b0101, 32'h1122_3344);
    rd(4'd3, 32'hDE22_BE44, "be_rd3");

    // Same-cycle write and read: forwarded vs pre-write word
    bus0.wen = 1'b1; bus0.waddr = 4'd5; bus0.wbyteena = 4'b1000; bus0.wdata = 32'hAAAA_AAAA;
    bus0.ren = 1'b1; bus0.raddr = 4'd5;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b0;
    tick();
    check("byp_vld", 32'(bus0.rvalid), 32'd1);
    check("byp_dat", bus0.rdata, 32'hAAAD_BEEF);
    check("nobyp_vld", 32'(bus1.rvalid), 32'd1);
    check("nobyp_dat", bus1.rdata, 32'hDEAD_BEEF);
    rd(4'd5, 32'hAAAD_BEEF, "after_byp");
    check("nobyp_after", bus1.rdata, 32'hAAAD_BEEF);

    // init_req with reads in flight; write attempted during init is dropped
    wr(4'd7, 4'b1111, 32'h1234_5678);
    bus0.ren = 1'b1; bus0.raddr = 4'd7;
    tick();
    bus0.init_req = 1'b1;
    tick();
    bus0.init_req = 1'b0; bus0.ren = 1'b0;
    bus0.wen = 1'b1; bus0.waddr = 4'd2; bus0.wbyteena = 4'hF; bus0.wdata = 32'd0;
    check("clr_rdy2", 32'(bus0.rdy), 32'd0);
    check("infl0_vld", 32'(bus0.rvalid), 32'd1);
    check("infl0_dat", bus0.rdata, 32'h1234_5678);
    tick();
    check("infl1_vld", 32'(bus0.rvalid), 32'd1);
    check("infl1_dat", bus0.rdata, 32'h1234_5678);
    check("clr_rdy3", 32'(bus0.rdy), 32'd0);
    for (int k = 4; k <= 14; k++) begin
      tick();
      check($sformatf("clr_rdy%0d", k), 32'(bus0.rdy), 32'(k == 14));
    end
    bus0.wen = 1'b0;
    rd(4'd7, IV, "clr_rd7");
    rd(4'd2, IV, "clr_rd2");

    // Asynchronous reset with reads in the pipeline, then again mid-init
    bus0.ren = 1'b1; bus0.raddr = 4'd3;
    tick();
    tick();
    bus0.ren = 1'b0;
    check("pre_rst_vld", 32'(bus0.rvalid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_vld", 32'(bus0.rvalid), 32'd0);
    check("arst_rdy", 32'(bus0.rdy), 32'd0);
    check("arst_dat", bus0.rdata, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("mid_rdy%0d", k), 32'(bus0.rdy), 32'd0);
    end
    reset_n = 1'b0;
    #1;
    check("mid_arst_rdy", 32'(bus0.rdy), 32'd0);
    check("mid_arst_vld", 32'(bus0.rvalid), 32'd0);
    tick();
    reset_n = 1'b1;
    init_count("reinit");
    rd(4'd3, IV, "reinit_rd3");

    // Out-of-range read and write
    rd(4'd13, IV, "oor_rd13");
    wr(4'd14, 4'hF, 32'h0000_0000);
    rd_all("oor_sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
